// File: rtl/wb_arbiter_2m_if.sv
// Bus bundle for the two-master Wishbone arbiter: master I, master D and the shared slave port.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface wb_arbiter_2m_if #(
  parameter int AW = 64,
  parameter int DW = 16,
  parameter int SW = 2
);

  logic [AW-1:0] iadr_i;
  logic [DW-1:0] idat_i;
  logic          iwe_i;
  logic          istb_i;
  logic          icyc_i;
  logic [SW-1:0] isel_i;
  logic          iack_o;
  logic [DW-1:0] idat_o;

  logic [AW-1:0] dadr_i;
  logic [DW-1:0] ddat_i;
  logic          dwe_i;
  logic          dstb_i;
  logic          dcyc_i;
  logic [SW-1:0] dsel_i;
  logic          dack_o;
  logic [DW-1:0] ddat_o;

  logic [AW-1:0] wbmadr_o;
  logic [DW-1:0] wbmdat_o;
  logic          wbmwe_o;
  logic          wbmstb_o;
  logic          wbmcyc_o;
  logic [SW-1:0] wbmsel_o;
  logic          wbmack_i;
  logic [DW-1:0] wbmdat_i;

  modport slave (
    input  iadr_i, idat_i, iwe_i, istb_i, icyc_i, isel_i,
    output iack_o, idat_o,
    input  dadr_i, ddat_i, dwe_i, dstb_i, dcyc_i, dsel_i,
    output dack_o, ddat_o,
    output wbmadr_o, wbmdat_o, wbmwe_o, wbmstb_o, wbmcyc_o, wbmsel_o,
    input  wbmack_i, wbmdat_i
  );

  modport master (
    output iadr_i, idat_i, iwe_i, istb_i, icyc_i, isel_i,
    input  iack_o, idat_o,
    output dadr_i, ddat_i, dwe_i, dstb_i, dcyc_i, dsel_i,
    input  dack_o, ddat_o,
    input  wbmadr_o, wbmdat_o, wbmwe_o, wbmstb_o, wbmcyc_o, wbmsel_o,
    output wbmack_i, wbmdat_i
  );

endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master (I fetch, D load/store) Wishbone arbiter; the owner keeps the bus for its whole CYC.
// Define WBARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise D wins every tie.
module wb_arbiter_2m (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  wb_arbiter_2m_if.slave        bus,
  output logic [1:0]            gnt_o
);

  // Encoding doubles as the grant code presented on gnt_o.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_I = 2'b01,
    OWN_D = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  state_t tie_winner;

`ifdef WBARB_ROUND_ROBIN_EN
  // last_gnt: 0 = I was the previous owner, 1 = D.
  logic last_gnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_gnt <= 1'b0;
    end else if (state == OWN_I && !bus.icyc_i) begin
      last_gnt <= 1'b0;
    end else if (state == OWN_D && !bus.dcyc_i) begin
      last_gnt <= 1'b1;
    end
  end

  assign tie_winner = last_gnt ? OWN_I : OWN_D;
`else
  assign tie_winner = OWN_D;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ownership is only released when the owner drops CYC; a waiting master takes over directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.icyc_i && bus.dcyc_i) begin
          state_nxt = tie_winner;
        end else if (bus.icyc_i) begin
          state_nxt = OWN_I;
        end else if (bus.dcyc_i) begin
          state_nxt = OWN_D;
        end
      end
      OWN_I: begin
        if (!bus.icyc_i) begin
          state_nxt = bus.dcyc_i ? OWN_D : IDLE;
        end
      end
      OWN_D: begin
        if (!bus.dcyc_i) begin
          state_nxt = bus.icyc_i ? OWN_I : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.wbmadr_o = '0;
    bus.wbmdat_o = '0;
    bus.wbmwe_o  = 1'b0;
    bus.wbmstb_o = 1'b0;
    bus.wbmcyc_o = 1'b0;
    bus.wbmsel_o = '0;
    bus.iack_o   = 1'b0;
    bus.idat_o   = '0;
    bus.dack_o   = 1'b0;
    bus.ddat_o   = '0;
    case (state)
      OWN_I: begin
        bus.wbmadr_o = bus.iadr_i;
        bus.wbmdat_o = bus.idat_i;
        bus.wbmwe_o  = bus.iwe_i;
        bus.wbmstb_o = bus.istb_i;
        bus.wbmcyc_o = bus.icyc_i;
        bus.wbmsel_o = bus.isel_i;
        bus.iack_o   = bus.wbmack_i & bus.icyc_i;
        bus.idat_o   = bus.wbmdat_i;
      end
      OWN_D: begin
        bus.wbmadr_o = bus.dadr_i;
        bus.wbmdat_o = bus.ddat_i;
        bus.wbmwe_o  = bus.dwe_i;
        bus.wbmstb_o = bus.dstb_i;
        bus.wbmcyc_o = bus.dcyc_i;
        bus.wbmsel_o = bus.dsel_i;
        bus.dack_o   = bus.wbmack_i & bus.dcyc_i;
        bus.ddat_o   = bus.wbmdat_i;
      end
      default: begin
      end
    endcase
  end

  assign gnt_o = state;

endmodule
